ecc_secded_encoder_pipe: RTL
============================

Name: ecc_secded_encoder_pipe

Overview:
- Write-side SECDED (72,64) check-bit generator; sits directly upstream of the ECC checker stage and produces the data_in/ecc_in pair that the checker consumes.
- Two-stage valid/ready pipeline with full backpressure: stage 1 registers input data, stage 2 computes and registers the 8 check bits alongside the data.
- Also counts delivered words and, when enabled, injects controlled errors to exercise the checker's single-error correction and double-error detection paths.

Parameters:
- CNT_W, 16, width of the delivered-word counter (saturating)

Ports:
- clock  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word this cycle
- data_in  input  64  data word to encode
- out_valid  output  1  encoded word available
- out_ready  input  1  downstream checker accepts the word
- data_out  output  64  data word (possibly error-injected)
- ecc_out  output  8  check bits: [7:1] Hamming, [0] data parity
- word_count  output  CNT_W  words delivered since reset, saturating
- inj_arm  input  1  arm one-shot error injection
- inj_double  input  1  0 = flip bit A only; 1 = flip bits A and B
- inj_bit_a  input  7  index into 72-bit {ecc_out,data_out}, 0..71
- inj_bit_b  input  7  second index, used only when inj_double=1
- inj_pending  output  1  injection armed, not yet applied

Behaviour:
- Codeword map (positions 1..71): data[0]→3, data[3:1]→7:5, data[10:4]→15:9, data[25:11]→31:17, data[56:26]→63:33, data[63:57]→71:65. Positions 0,1,2,4,8,16,32,64 are zero.
- ecc[k], k=1..7: XOR of the codeword positions j with bit (k-1) of j set.
- ecc[0]: XOR of all 64 data bits only. Check bits are excluded from this parity.
- Handshake: a transfer occurs on a cycle with valid && ready. Once out_valid is asserted, data_out and ecc_out hold stable until accepted.
- Ready chaining:
  - s2_ready = !s2_valid || out_ready
  - s1_ready = !s1_valid || s2_ready
  - in_ready = s1_ready (a combinational path from out_ready is permitted)
- Latency: a word accepted at cycle N appears on out_valid at N+2 when there is no stall. Throughput is 1 word/cycle with out_ready held high.
- Stall: with out_ready=0, at most 2 words are held; in_ready deasserts once both stages are full. No word is dropped or duplicated.
- Same-cycle events: an output transfer and an input transfer in the same cycle are both honoured; the pipeline advances by one.
- word_count: increments by 1 on each out_valid && out_ready; holds at 2^CNT_W-1.
- Reset (including mid-operation):
  - next cycle: s1_valid=0, s2_valid=0, out_valid=0, data_out=0, ecc_out=0, word_count=0, inj_pending=0
  - in-flight words are discarded
  - in_ready=1 in the first cycle after reset deasserts
- Bit indices: 0..63 select data_out bits; 64..71 select ecc_out[0..7]. Indices above 71 are ignored (no flip) but still consume the arm.

Optional Feature:
- Macro: ECC_ERR_INJECT_EN.
- Defined:
  - A cycle with inj_arm=1 sets inj_pending and latches inj_double, inj_bit_a and inj_bit_b.
  - The next word moving into stage 2 has its listed bits inverted after ECC generation, then inj_pending clears.
  - Arming while pending overwrites the latched values.
  - If arming coincides with a stage-2 load, the new arm applies to the following word.
  - inj_double=1 with bit_a==bit_b flips nothing.
- Undefined: inj_* inputs are ignored, inj_pending is tied to 0, and no injection logic is synthesised.

Test Plan:
- Reset, then data_in=64'h0, hold out_ready=1 → out_valid at +2 cycles; data_out=0, ecc_out=8'h00; word_count=1.
- data_in=64'h1 → ecc_out=8'h07. data_in=64'h8000_0000_0000_0000 → ecc_out=8'h8F.
- Stream 6 words with out_ready=0 → in_ready drops after 2 accepts. Then release out_ready=1 → all words emerge in order with matching ECC; word_count=6.
- Assert reset while 2 words are in flight → out_valid=0, word_count=0 the next cycle; the held words never appear.
- ECC_ERR_INJECT_EN: arm inj_bit_a=3, single, then send data 64'h0 → data_out=64'h8, ecc_out=8'h00; inj_pending clears. Feeding this pair to the checker gives error_flag=01 and corrected data 0.
- ECC_ERR_INJECT_EN: arm double with bits 0 and 65, then send data 64'h0 → data_out=64'h1, ecc_out=8'h02; the checker reports error_flag=10.
- CNT_W=4: deliver 20 words → word_count saturates at 15.

Source files
------------

// File: rtl/ecc_secded_encoder_pipe.sv
// ============================================================================
// ecc_secded_encoder_pipe : two-stage SECDED (72,64) check-bit generator with
// valid/ready backpressure, saturating delivered-word counter and optional
// one-shot error injection (enabled by defining ECC_ERR_INJECT_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ecc_secded_encoder_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      data_out,
  output logic [7:0]       ecc_out,
  output logic [CNT_W-1:0] word_count,
  input  logic             inj_arm,
  input  logic             inj_double,
  input  logic [6:0]       inj_bit_a,
  input  logic [6:0]       inj_bit_b,
  output logic             inj_pending
);

  function automatic logic [7:0] calc_ecc(input logic [63:0] d);
    logic [71:0] cw;
    logic [7:0]  e;
    cw         = '0;
    cw[3]      = d[0];
    cw[7:5]    = d[3:1];
    cw[15:9]   = d[10:4];
    cw[31:17]  = d[25:11];
    cw[63:33]  = d[56:26];
    cw[71:65]  = d[63:57];
    e          = '0;
    for (int k = 1; k < 8; k++) begin
      for (int j = 0; j < 72; j++) begin
        if (((j >> (k - 1)) & 1) == 1) e[k] = e[k] ^ cw[j];
      end
    end
    // Overall parity covers data only, not the Hamming bits.
    e[0] = ^d;
    return e;
  endfunction

  logic        s1_valid;
  logic [63:0] s1_data;
  logic        s2_valid;
  logic        s1_ready;
  logic        s2_ready;
  logic        s2_load;
  logic [71:0] flip_mask;
  logic [CNT_W-1:0] cnt_max;

  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s2_valid;
  assign s2_load   = s2_ready && s1_valid;
  assign cnt_max   = '1;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      data_out <= '0;
      ecc_out  <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) {ecc_out, data_out} <= {calc_ecc(s1_data), s1_data} ^ flip_mask;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_count <= '0;
    end else if (out_valid && out_ready && (word_count != cnt_max)) begin
      word_count <= word_count + CNT_W'(1);
    end
  end

`ifdef ECC_ERR_INJECT_EN
  logic       inj_dbl_q;
  logic [6:0] inj_a_q;
  logic [6:0] inj_b_q;

  // XOR of the two one-hot masks makes a==b cancel; indices above 71 match nothing.
  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < 72; i++) begin
      flip_mask[i] = (inj_a_q == 7'(i)) ^ (inj_dbl_q && (inj_b_q == 7'(i)));
    end
    if (!inj_pending) flip_mask = '0;
  end

  // A fresh arm wins over the clear so it targets the word after the current load.
  always_ff @(posedge clock) begin
    if (reset) begin
      inj_pending <= 1'b0;
      inj_dbl_q   <= 1'b0;
      inj_a_q     <= '0;
      inj_b_q     <= '0;
    end else if (inj_arm) begin
      inj_pending <= 1'b1;
      inj_dbl_q   <= inj_double;
      inj_a_q     <= inj_bit_a;
      inj_b_q     <= inj_bit_b;
    end else if (s2_load) begin
      inj_pending <= 1'b0;
    end
  end
`else
  logic unused_inj;
  assign unused_inj  = ^{inj_arm, inj_double, inj_bit_a, inj_bit_b};
  assign flip_mask   = '0;
  assign inj_pending = 1'b0;
`endif

endmodule

`default_nettype wire
